// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with in-flight PC tracking, redirect squashing and an instruction queue.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_if_pc [DEPTH];
  logic [AW-1:0]   r_if_wp, r_if_rp;
  logic [CW-1:0]   r_inflight, r_drop;
  logic [XLEN-1:0] r_q_pc [DEPTH];
  logic [31:0]     r_q_data [DEPTH];
  logic [AW-1:0]   r_q_wp, r_q_rp;
  logic [CW-1:0]   r_q_cnt;
  logic w_fetch, w_redir, w_credit, w_req_hs, w_rsp, w_keep, w_pop;
  // Outputs are gated by rst so nothing leaks out while reset is being applied.
  assign w_fetch  = rst && r_state == FETCH;
  assign w_redir  = w_fetch && redirect_valid;
  assign w_credit = ({1'b0, r_inflight} + {1'b0, r_q_cnt}) < (CW + 1)'(DEPTH);
  assign imem_req_valid = w_fetch && !redirect_valid && w_credit;
  assign imem_req_addr  = r_pc;
  assign w_req_hs = imem_req_valid && imem_req_ready;
  assign w_rsp    = imem_rsp_valid && r_inflight != '0;
  assign w_keep   = w_rsp && r_drop == '0 && !w_redir;
  assign inst_valid = w_fetch && !redirect_valid && r_q_cnt != '0;
  assign inst_data  = r_q_data[r_q_rp];
  assign inst_pc    = r_q_pc[r_q_rp];
  assign w_pop      = inst_valid && inst_ready;
  always_ff @(posedge clk) begin
    if (w_req_hs) r_if_pc[r_if_wp] <= r_pc;
    if (w_keep) begin
      r_q_pc[r_q_wp]   <= r_if_pc[r_if_rp];
      r_q_data[r_q_wp] <= imem_rsp_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_if_wp    <= '0;
      r_if_rp    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_q_wp     <= '0;
      r_q_rp     <= '0;
      r_q_cnt    <= '0;
    end else begin
      r_state <= FETCH;
      r_pc <= w_redir ? (redirect_pc & ~XLEN'(3)) : w_req_hs ? r_pc + XLEN'(4) : r_pc;
      if (w_req_hs) r_if_wp <= r_if_wp + AW'(1);
      if (w_rsp) r_if_rp <= r_if_rp + AW'(1);
      r_inflight <= r_inflight + CW'(w_req_hs) - CW'(w_rsp);
      // Everything still outstanding after this edge's response belongs to the wrong path.
      if (w_redir) r_drop <= r_inflight - CW'(w_rsp);
      else if (w_rsp && r_drop != '0) r_drop <= r_drop - CW'(1);
      if (w_redir) begin
        r_q_wp  <= '0;
        r_q_rp  <= '0;
        r_q_cnt <= '0;
      end else begin
        if (w_keep) r_q_wp <= r_q_wp + AW'(1);
        if (w_pop) r_q_rp <= r_q_rp + AW'(1);
        r_q_cnt <= r_q_cnt + CW'(w_keep) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a queued memory model with holdable responses.
module tb_fetch_unit;
  logic        clk = 0, rst = 0;
  logic        imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        inst_valid, inst_ready = 1;
  logic [31:0] inst_data, inst_pc;
  logic        hold = 0;
  int checks = 0, errors = 0;
  logic [31:0] mq[$], reqs[$], got_pc[$], got_data[$];

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // In-order memory: responds at the earliest one edge after the request unless held.
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      imem_rsp_valid <= 0;
    end else begin
      imem_rsp_valid <= 0;
      if (!hold && mq.size() > 0) begin
        imem_rsp_valid <= 1;
        imem_rsp_data  <= f(mq.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        reqs.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) begin
        got_pc.push_back(inst_pc);
        got_data.push_back(inst_data);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    reqs.delete();
    got_pc.delete();
    got_data.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    cyc(2);
    clear_logs();
    rst = 1;
  endtask

  initial begin
    int n0;
    bit ok;
    // Reset state and first request
    cyc(2);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    clear_logs();
    rst = 1;
    #1 check("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("idle_inst_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h80000000);
    cyc(20);
    check("stream_req_cnt", {31'b0, reqs.size() >= 8}, 32'd1);
    check("stream_inst_cnt", {31'b0, got_pc.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < reqs.size(); i++) check("stream_addr", reqs[i], 32'h80000000 + 32'(4 * i));
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      check("stream_pc", got_pc[i], 32'h80000000 + 32'(4 * i));
      check("stream_data", got_data[i], f(32'h80000000 + 32'(4 * i)));
    end

    // Backpressure from decode: exactly DEPTH requests
    inst_ready = 0;
    do_reset();
    cyc(15);
    check("bp_req_cnt", reqs.size(), 32'd4);
    check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("bp_inst_pc", inst_pc, 32'h80000000);
    check("bp_inst_data", inst_data, f(32'h80000000));
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0;
    cyc(5);
    check("bp_req_cnt2", reqs.size(), 32'd5);
    check("bp_got_cnt", got_pc.size(), 32'd1);
    if (reqs.size() > 4) check("bp_req_addr5", reqs[4], 32'h80000010);
    check("bp_head_pc", inst_pc, 32'h80000004);

    // Redirect with three requests outstanding
    inst_ready = 1;
    hold = 1;
    do_reset();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (reqs.size() >= 3) begin
        imem_req_ready = 0;
        ok = 1;
      end
    end
    check("rd_three_out", {31'b0, ok}, 32'd1);
    check("rd_req_cnt", reqs.size(), 32'd3);
    cyc(2);
    redirect_valid = 1;
    redirect_pc = 32'h80001002;
    imem_req_ready = 1;
    #1 check("rd_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    check("rd_inst_blocked", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 0;
    #1 check("rd_new_addr", imem_req_addr, 32'h80001000);
    check("rd_new_valid", {31'b0, imem_req_valid}, 32'd1);
    hold = 0;
    cyc(20);
    check("rd_got_some", {31'b0, got_pc.size() >= 3}, 32'd1);
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      check("rd_pc", got_pc[i], 32'h80001000 + 32'(4 * i));
      check("rd_data", got_data[i], f(32'h80001000 + 32'(4 * i)));
    end

    // Redirect coinciding with a response, into the top of the address space
    do_reset();
    cyc(10);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = imem_rsp_valid && inst_valid;
    end
    check("co_setup", {31'b0, ok}, 32'd1);
    n0 = got_pc.size();
    redirect_valid = 1;
    redirect_pc = 32'hFFFFFFFF;
    #1 check("co_inst_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 0;
    check("co_no_hs", got_pc.size(), n0);
    #1 check("co_addr", imem_req_addr, 32'hFFFFFFFC);
    @(negedge clk);
    check("wrap_addr", imem_req_addr, 32'h00000000);
    cyc(15);
    check("co_got_cnt", {31'b0, got_pc.size() >= n0 + 3}, 32'd1);
    if (got_pc.size() >= n0 + 3) begin
      check("co_pc0", got_pc[n0], 32'hFFFFFFFC);
      check("co_pc1", got_pc[n0 + 1], 32'h00000000);
      check("co_pc2", got_pc[n0 + 2], 32'h00000004);
      check("co_data0", got_data[n0], f(32'hFFFFFFFC));
    end

    // Reset mid-operation with a full queue
    inst_ready = 0;
    cyc(10);
    check("mid_full_valid", {31'b0, inst_valid}, 32'd1);
    rst = 0;
    #1 check("mid_rst_inst", {31'b0, inst_valid}, 32'd0);
    check("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    check("mid_after_inst", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    clear_logs();
    inst_ready = 1;
    rst = 1;
    cyc(12);
    check("mid_req0", reqs.size() > 0 ? reqs[0] : 32'hDEADBEEF, 32'h80000000);
    check("mid_pc0", got_pc.size() > 0 ? got_pc[0] : 32'hDEADBEEF, 32'h80000000);
    check("mid_pc1", got_pc.size() > 1 ? got_pc[1] : 32'hDEADBEEF, 32'h80000004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
